// File: rtl/insn_seq.sv
// Instruction sequencer: fetches from instruction SRAM, holds the config register file,
// and dispatches non-blocking engine starts with nested hardware loops and barrier sync.
//
// state | meaning
// IDLE  | waiting for start
// DEC   | decoding idata at iaddr, one instruction per cycle
// STALL | held RUN waiting for its engine to finish
// SYNC  | barrier: waiting for all engines idle
// DRAIN | EOC seen, waiting for all engines idle before HALT
// HALT  | program complete, done asserted, frozen until rst
// ERR   | illegal op, loop over/underflow or bad engine id, frozen until rst
module insn_seq #(
    parameter int IADDR_W    = 13,
    parameter int DATA_W     = 32,
    parameter int OP_W       = 5,
    parameter int NUM_ENG    = 4,
    parameter int NUM_CFG    = 16,
    parameter int LOOP_DEPTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [IADDR_W-1:0]                  iaddr,
    input  logic [DATA_W-1:0]                   idata,
    output logic [NUM_ENG-1:0]                  eng_start,
    output logic [DATA_W-OP_W-4:0]              eng_arg,
    input  logic [NUM_ENG-1:0]                  eng_done,
    output logic [NUM_CFG*(DATA_W-OP_W-4)-1:0]  cfg_flat,
    output logic                                busy,
    output logic                                done,
    output logic                                err
);
    localparam int ARG_W = DATA_W - OP_W - 3;
    localparam int CFG_W = DATA_W - OP_W - 4;
    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);

    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_CFG  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_RUN  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LOOP = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ENDL = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SYNC = OP_W'(5);
    localparam logic [OP_W-1:0] OP_EOC  = OP_W'(31);

    typedef enum logic [2:0] {
        S_IDLE, S_DEC, S_STALL, S_SYNC, S_DRAIN, S_HALT, S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [IADDR_W-1:0]   iaddr_q, iaddr_d;
    logic [CFG_W-1:0]     cfg_q [NUM_CFG];
    logic [CFG_W-1:0]     cfg_d [NUM_CFG];
    logic [IADDR_W-1:0]   lp_start_q [LOOP_DEPTH];
    logic [IADDR_W-1:0]   lp_start_d [LOOP_DEPTH];
    logic [15:0]          lp_cnt_q [LOOP_DEPTH];
    logic [15:0]          lp_cnt_d [LOOP_DEPTH];
    logic [SP_W-1:0]      sp_q, sp_d;
    logic [NUM_ENG-1:0]   eng_busy_q, eng_busy_d;
    logic [NUM_ENG-1:0]   eng_start_q, eng_start_d;
    logic [ARG_W-1:0]     eng_arg_q, eng_arg_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [OP_W-1:0]      op;
    logic [2:0]           eid;
    logic [ARG_W-1:0]     arg;
    logic [3:0]           cidx;
    logic [CFG_W-1:0]     cval;
    logic [15:0]          lcnt;

    logic                 issue, run_ok, eid_bad;
    logic [IADDR_W-1:0]   iaddr_inc, top_start;
    logic [15:0]          top_cnt;
    logic [NUM_ENG-1:0]   pending;

    assign op   = idata[DATA_W-1 -: OP_W];
    assign eid  = idata[DATA_W-OP_W-1 -: 3];
    assign cidx = idata[DATA_W-OP_W-1 -: 4];
    assign arg  = idata[ARG_W-1:0];
    assign cval = idata[CFG_W-1:0];
    assign lcnt = idata[15:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            iaddr_q     <= '0;
            sp_q        <= '0;
            eng_busy_q  <= '0;
            eng_start_q <= '0;
            eng_arg_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int k = 0; k < NUM_CFG; k++) cfg_q[k] <= '0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                lp_start_q[i] <= '0;
                lp_cnt_q[i]   <= '0;
            end
        end else begin
            state_q     <= state_d;
            iaddr_q     <= iaddr_d;
            sp_q        <= sp_d;
            eng_busy_q  <= eng_busy_d;
            eng_start_q <= eng_start_d;
            eng_arg_q   <= eng_arg_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cfg_q       <= cfg_d;
            lp_start_q  <= lp_start_d;
            lp_cnt_q    <= lp_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iaddr_d    = iaddr_q;
        cfg_d      = cfg_q;
        sp_d       = sp_q;
        lp_start_d = lp_start_q;
        lp_cnt_d   = lp_cnt_q;
        eng_arg_d  = eng_arg_q;
        done_d     = done_q;
        err_d      = err_q;
        issue      = 1'b0;
        iaddr_inc  = iaddr_q + IADDR_W'(1);
        pending    = eng_busy_q & ~eng_done;
        eid_bad    = int'(eid) >= NUM_ENG;

        // A done arriving this cycle frees the engine for an immediate restart.
        run_ok = 1'b0;
        for (int e = 0; e < NUM_ENG; e++)
            if (int'(eid) == e) run_ok = !eng_busy_q[e] || eng_done[e];

        top_start = '0;
        top_cnt   = '0;
        for (int i = 0; i < LOOP_DEPTH; i++)
            if (int'(sp_q) == i + 1) begin
                top_start = lp_start_q[i];
                top_cnt   = lp_cnt_q[i];
            end

        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_DEC;
                iaddr_d = '0;
            end
            S_DEC: case (op)
                OP_NOP: iaddr_d = iaddr_inc;
                OP_CFG: begin
                    for (int k = 0; k < NUM_CFG; k++)
                        if (int'(cidx) == k) cfg_d[k] = cval;
                    iaddr_d = iaddr_inc;
                end
                OP_RUN: begin
                    if (eid_bad) state_d = S_ERR;
                    else if (run_ok) begin
                        issue   = 1'b1;
                        iaddr_d = iaddr_inc;
                    end else state_d = S_STALL;
                end
                OP_LOOP: begin
                    if (int'(sp_q) == LOOP_DEPTH) state_d = S_ERR;
                    else begin
                        for (int i = 0; i < LOOP_DEPTH; i++)
                            if (int'(sp_q) == i) begin
                                lp_start_d[i] = iaddr_inc;
                                lp_cnt_d[i]   = (lcnt == 16'd0) ? 16'd1 : lcnt;
                            end
                        sp_d    = sp_q + SP_W'(1);
                        iaddr_d = iaddr_inc;
                    end
                end
                OP_ENDL: begin
                    if (sp_q == '0) state_d = S_ERR;
                    else if (top_cnt > 16'd1) begin
                        for (int i = 0; i < LOOP_DEPTH; i++)
                            if (int'(sp_q) == i + 1) lp_cnt_d[i] = top_cnt - 16'd1;
                        iaddr_d = top_start;
                    end else begin
                        sp_d    = sp_q - SP_W'(1);
                        iaddr_d = iaddr_inc;
                    end
                end
                OP_SYNC: state_d = S_SYNC;
                OP_EOC:  state_d = S_DRAIN;
                default: state_d = S_ERR;
            endcase
            // iaddr is held during the stall, so idata still presents the same RUN.
            S_STALL: if (run_ok) begin
                issue   = 1'b1;
                iaddr_d = iaddr_inc;
                state_d = S_DEC;
            end
            S_SYNC: if (pending == '0) begin
                iaddr_d = iaddr_inc;
                state_d = S_DEC;
            end
            S_DRAIN: if (pending == '0) begin
                state_d = S_HALT;
                done_d  = 1'b1;
            end
            default: ;
        endcase

        if (state_d == S_ERR) err_d = 1'b1;

        eng_start_d = '0;
        for (int e = 0; e < NUM_ENG; e++)
            eng_start_d[e] = issue && (int'(eid) == e);
        if (issue) eng_arg_d = arg;
        eng_busy_d = pending | eng_start_d;
    end

    always_comb begin
        iaddr     = iaddr_q;
        eng_start = eng_start_q;
        eng_arg   = eng_arg_q;
        done      = done_q;
        err       = err_q;
        busy      = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_ERR);
        cfg_flat  = '0;
        for (int k = 0; k < NUM_CFG; k++)
            cfg_flat[k*CFG_W +: CFG_W] = cfg_q[k];
    end
endmodule

// File: tb/tb_insn_seq.sv
// Directed bench for insn_seq: small programs in a modelled instruction SRAM,
// one task per scenario with hand-computed expectations.
module tb_insn_seq;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [12:0]  iaddr;
    logic [31:0]  idata;
    logic [3:0]   eng_start;
    logic [23:0]  eng_arg;
    logic [3:0]   eng_done;
    logic [3:0]   eng_done_man = '0;
    logic [3:0]   eng_done_auto = '0;
    logic [367:0] cfg_flat;
    logic         busy, done, err;

    logic [31:0]  imem [64];
    logic         auto_done = 1'b0;
    int           start_cnt [4] = '{0, 0, 0, 0};
    int           multi_hot = 0;
    int           vectors = 0;
    int           miscompares = 0;

    assign idata    = (iaddr < 13'd64) ? imem[iaddr[5:0]] : 32'd0;
    assign eng_done = eng_done_man | eng_done_auto;

    insn_seq dut (
        .clk(clk), .rst(rst), .start(start), .iaddr(iaddr), .idata(idata),
        .eng_start(eng_start), .eng_arg(eng_arg), .eng_done(eng_done),
        .cfg_flat(cfg_flat), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Engine model: counts start pulses; in auto mode finishes in the cycle the pulse is seen.
    always @(negedge clk) begin
        eng_done_auto = '0;
        if ($countones(eng_start) > 1) multi_hot++;
        for (int e = 0; e < 4; e++)
            if (eng_start[e]) start_cnt[e]++;
        if (auto_done) eng_done_auto = eng_start;
    end

    function automatic logic [31:0] i_cfg(input logic [3:0] idx, input logic [22:0] v);
        return {5'd1, idx, v};
    endfunction
    function automatic logic [31:0] i_run(input logic [2:0] e, input logic [23:0] a);
        return {5'd2, e, a};
    endfunction
    function automatic logic [31:0] i_loop(input logic [15:0] c);
        return {5'd3, 11'd0, c};
    endfunction
    function automatic logic [31:0] i_op(input logic [4:0] op);
        return {op, 27'd0};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = i_op(5'd31);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; eng_done_man = '0; auto_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Returns at the negedge of cycle 1: DEC with iaddr 0.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (iaddr !== 13'd0) begin miscompares++; $display("FAIL reset_iaddr: got %0h want 0", iaddr); end
        vectors++;
        if ({eng_start, eng_arg} !== 28'd0) begin miscompares++; $display("FAIL reset_eng: start %b arg %h want 0", eng_start, eng_arg); end
        vectors++;
        if ({busy, done, err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: busy/done/err %b want 000", {busy, done, err}); end
        vectors++;
        if (cfg_flat !== 368'd0) begin miscompares++; $display("FAIL reset_cfg: got %h want 0", cfg_flat); end
    endtask

    task automatic test_config();
        logic [367:0] exp_cfg;
        exp_cfg = '0;
        exp_cfg[3*23 +: 23] = 23'h12345;
        do_reset();
        clear_prog();
        imem[0] = i_cfg(4'd3, 23'h12345);
        imem[1] = i_op(5'd31);
        pulse_start();
        @(negedge clk); // cycle 2
        vectors++;
        if (cfg_flat !== exp_cfg) begin miscompares++; $display("FAIL cfg_write: got %h want %h", cfg_flat, exp_cfg); end
        @(negedge clk); // cycle 3, DRAIN
        vectors++;
        if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL cfg_drain: busy/done %b want 10", {busy, done}); end
        @(negedge clk); // cycle 4, HALT
        vectors++;
        if ({busy, done, err} !== 3'b010) begin miscompares++; $display("FAIL cfg_done: busy/done/err %b want 010", {busy, done, err}); end
    endtask

    task automatic test_overlap();
        do_reset();
        clear_prog();
        imem[0] = i_run(3'd0, 24'd5);
        imem[1] = i_run(3'd1, 24'd6);
        imem[2] = i_run(3'd0, 24'd7);
        imem[3] = i_op(5'd5);
        imem[4] = i_op(5'd31);
        pulse_start();
        @(negedge clk); // cycle 2: pulse from RUN issued in cycle 1
        vectors++;
        if ({eng_start, eng_arg} !== {4'b0001, 24'd5}) begin miscompares++; $display("FAIL ovl_start0: start %b arg %0d want 0001/5", eng_start, eng_arg); end
        @(negedge clk); // cycle 3
        vectors++;
        if ({eng_start, eng_arg} !== {4'b0010, 24'd6}) begin miscompares++; $display("FAIL ovl_start1: start %b arg %0d want 0010/6", eng_start, eng_arg); end
        for (int cyc = 4; cyc <= 13; cyc++) begin
            @(negedge clk);
            vectors++;
            if ({iaddr, eng_start, eng_arg, busy} !== {13'd2, 4'b0000, 24'd6, 1'b1}) begin
                miscompares++;
                $display("FAIL ovl_stall c%0d: iaddr %0d start %b arg %0d busy %b want 2/0000/6/1", cyc, iaddr, eng_start, eng_arg, busy);
            end
            eng_done_man = (cyc == 5) ? 4'b0010 : 4'b0000;
        end
        @(negedge clk); // cycle 14: e0 completes
        vectors++;
        if ({iaddr, eng_start} !== {13'd2, 4'b0000}) begin miscompares++; $display("FAIL ovl_c14: iaddr %0d start %b want 2/0000", iaddr, eng_start); end
        eng_done_man = 4'b0001;
        @(negedge clk); // cycle 15
        eng_done_man = 4'b0000;
        vectors++;
        if ({eng_start, eng_arg, iaddr} !== {4'b0001, 24'd7, 13'd3}) begin miscompares++; $display("FAIL ovl_restart: start %b arg %0d iaddr %0d want 0001/7/3", eng_start, eng_arg, iaddr); end
        @(negedge clk); // cycle 16: SYNC waiting
        vectors++;
        if ({iaddr, busy} !== {13'd3, 1'b1}) begin miscompares++; $display("FAIL ovl_sync: iaddr %0d busy %b want 3/1", iaddr, busy); end
        eng_done_man = 4'b0001;
        @(negedge clk); // cycle 17
        eng_done_man = 4'b0000;
        vectors++;
        if (iaddr !== 13'd4) begin miscompares++; $display("FAIL ovl_sync_exit: iaddr %0d want 4", iaddr); end
        for (int n = 0; n < 10 && done !== 1'b1; n++) @(negedge clk);
        vectors++;
        if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL ovl_done: done/err %b want 10", {done, err}); end
    endtask

    task automatic test_nested_loop();
        int b0, b1, brest;
        do_reset();
        auto_done = 1'b1;
        clear_prog();
        imem[0] = i_loop(16'd3);
        imem[1] = i_loop(16'd2);
        imem[2] = i_run(3'd0, 24'h11);
        imem[3] = i_op(5'd4);
        imem[4] = i_op(5'd4);
        imem[5] = i_op(5'd5);
        imem[6] = i_op(5'd31);
        b0 = start_cnt[0];
        brest = start_cnt[1] + start_cnt[2] + start_cnt[3];
        pulse_start();
        for (int n = 0; n < 200 && done !== 1'b1; n++) @(negedge clk);
        vectors++;
        if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL loop_done: done/err %b want 10", {done, err}); end
        vectors++;
        if (start_cnt[0] - b0 !== 6) begin miscompares++; $display("FAIL loop_count: e0 starts %0d want 6", start_cnt[0] - b0); end
        vectors++;
        if (start_cnt[1] + start_cnt[2] + start_cnt[3] - brest !== 0) begin miscompares++; $display("FAIL loop_other: stray starts %0d want 0", start_cnt[1] + start_cnt[2] + start_cnt[3] - brest); end
        vectors++;
        if (iaddr !== 13'd6) begin miscompares++; $display("FAIL loop_halt_addr: iaddr %0d want 6", iaddr); end

        // A count of 0 runs the body once.
        do_reset();
        auto_done = 1'b1;
        clear_prog();
        imem[0] = i_loop(16'd0);
        imem[1] = i_run(3'd1, 24'd3);
        imem[2] = i_op(5'd4);
        imem[3] = i_op(5'd31);
        b1 = start_cnt[1];
        pulse_start();
        for (int n = 0; n < 50 && done !== 1'b1; n++) @(negedge clk);
        vectors++;
        if ({done, err, iaddr} !== {2'b10, 13'd3}) begin miscompares++; $display("FAIL loop0_done: done/err %b iaddr %0d want 10/3", {done, err}, iaddr); end
        vectors++;
        if (start_cnt[1] - b1 !== 1) begin miscompares++; $display("FAIL loop0_count: e1 starts %0d want 1", start_cnt[1] - b1); end
    endtask

    task automatic test_loop_errors();
        int base, cyc;
        logic [12:0] bad_addr;
        for (int k = 0; k < 4; k++) begin
            do_reset();
            auto_done = 1'b1;
            clear_prog();
            bad_addr = 13'd0;
            case (k)
                0: begin
                    imem[0] = i_loop(16'd1); imem[1] = i_loop(16'd1); imem[2] = i_loop(16'd1);
                    imem[3] = i_run(3'd0, 24'd1); bad_addr = 13'd2;
                end
                1: begin imem[0] = i_op(5'd4); imem[1] = i_run(3'd0, 24'd1); end
                2: begin imem[0] = i_op(5'd7); imem[1] = i_run(3'd0, 24'd1); end
                default: begin imem[0] = i_run(3'd5, 24'd1); imem[1] = i_run(3'd0, 24'd1); end
            endcase
            base = start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3];
            pulse_start();
            cyc = 1;
            while (err !== 1'b1 && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            vectors++;
            if (cyc !== int'(bad_addr) + 2) begin miscompares++; $display("FAIL err_latency case%0d: err at cycle %0d want %0d", k, cyc, int'(bad_addr) + 2); end
            repeat (3) @(negedge clk);
            pulse_start();
            repeat (3) @(negedge clk);
            vectors++;
            if ({err, done, busy, iaddr} !== {3'b100, bad_addr}) begin
                miscompares++;
                $display("FAIL err_frozen case%0d: err/done/busy %b iaddr %0d want 100/%0d", k, {err, done, busy}, iaddr, bad_addr);
            end
            vectors++;
            if (start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3] - base !== 0 || cfg_flat !== 368'd0) begin
                miscompares++;
                $display("FAIL err_side_effect case%0d: starts %0d cfg %h want 0/0", k, start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3] - base, cfg_flat);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_prog();
        imem[0] = i_run(3'd2, 24'd1);
        imem[1] = i_run(3'd2, 24'd2);
        imem[2] = i_op(5'd5);
        imem[3] = i_op(5'd31);
        pulse_start();
        @(negedge clk); // cycle 2: first start visible, RUN e2 decoding with done arriving
        vectors++;
        if ({eng_start, eng_arg} !== {4'b0100, 24'd1}) begin miscompares++; $display("FAIL b2b_first: start %b arg %0d want 0100/1", eng_start, eng_arg); end
        eng_done_man = 4'b0100;
        @(negedge clk); // cycle 3
        eng_done_man = 4'b0000;
        vectors++;
        if ({eng_start, eng_arg, iaddr} !== {4'b0100, 24'd2, 13'd2}) begin miscompares++; $display("FAIL b2b_bypass: start %b arg %0d iaddr %0d want 0100/2/2", eng_start, eng_arg, iaddr); end
        for (int cyc = 4; cyc <= 8; cyc++) begin
            @(negedge clk);
            vectors++;
            if ({iaddr, busy} !== {13'd2, 1'b1}) begin miscompares++; $display("FAIL b2b_sync_wait c%0d: iaddr %0d busy %b want 2/1", cyc, iaddr, busy); end
        end
        eng_done_man = 4'b0100;
        @(negedge clk); // cycle 9
        eng_done_man = 4'b0000;
        vectors++;
        if (iaddr !== 13'd3) begin miscompares++; $display("FAIL b2b_sync_exit: iaddr %0d want 3", iaddr); end
        for (int n = 0; n < 10 && done !== 1'b1; n++) @(negedge clk);
        vectors++;
        if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL b2b_done: done/err %b want 10", {done, err}); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        clear_prog();
        imem[0] = i_run(3'd0, 24'd1);
        imem[1] = i_run(3'd0, 24'd2);
        imem[2] = i_op(5'd31);
        pulse_start();
        @(negedge clk); // cycle 2
        @(negedge clk); // cycle 3: stalled on second RUN
        vectors++;
        if ({iaddr, busy} !== {13'd1, 1'b1}) begin miscompares++; $display("FAIL mrst_stall: iaddr %0d busy %b want 1/1", iaddr, busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({iaddr, eng_start, eng_arg, busy, done, err} !== {13'd0, 4'b0000, 24'd0, 3'b000}) begin
            miscompares++;
            $display("FAIL mrst_state: iaddr %0d start %b arg %0d busy/done/err %b want all 0", iaddr, eng_start, eng_arg, {busy, done, err});
        end
        eng_done_man = 4'b0001; // late completion from the aborted run
        @(negedge clk);
        eng_done_man = 4'b0000;
        vectors++;
        if ({iaddr, busy, eng_start} !== {13'd0, 1'b0, 4'b0000}) begin miscompares++; $display("FAIL mrst_late_done: iaddr %0d busy %b start %b want 0/0/0000", iaddr, busy, eng_start); end
        pulse_start();
        @(negedge clk); // cycle 2
        vectors++;
        if ({eng_start, eng_arg} !== {4'b0001, 24'd1}) begin miscompares++; $display("FAIL mrst_rerun: start %b arg %0d want 0001/1", eng_start, eng_arg); end
        @(negedge clk); // cycle 3
        vectors++;
        if ({iaddr, eng_start} !== {13'd1, 4'b0000}) begin miscompares++; $display("FAIL mrst_restall: iaddr %0d start %b want 1/0000", iaddr, eng_start); end
        eng_done_man = 4'b0001;
        @(negedge clk); // cycle 4
        eng_done_man = 4'b0000;
        vectors++;
        if ({eng_start, eng_arg} !== {4'b0001, 24'd2}) begin miscompares++; $display("FAIL mrst_second: start %b arg %0d want 0001/2", eng_start, eng_arg); end
        eng_done_man = 4'b0001;
        @(negedge clk);
        eng_done_man = 4'b0000;
        for (int n = 0; n < 10 && done !== 1'b1; n++) @(negedge clk);
        vectors++;
        if ({done, err} !== 2'b10) begin miscompares++; $display("FAIL mrst_done: done/err %b want 10", {done, err}); end
    endtask

    initial begin
        clear_prog();
        test_reset();
        test_config();
        test_overlap();
        test_nested_loop();
        test_loop_errors();
        test_back_to_back();
        test_mid_reset();
        vectors++;
        if (multi_hot !== 0) begin miscompares++; $display("FAIL onehot: %0d cycles with multiple start bits, want 0", multi_hot); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/insn_seq.md
Name: insn_seq

Overview:
Parametrised successor of the layer instruction decoder. It fetches 32-bit instructions from instruction memory and holds a register file of layer/engine configuration words. It dispatches work to NUM_ENG compute engines with overlapped, non-blocking starts, and supports nested hardware loops, barrier sync, and a halt/error status in place of simulation-only termination. It sits between instruction SRAM and the FC/conv/pool engines.

Parameters:
IADDR_W, 13, instruction address width
DATA_W, 32, instruction width
OP_W, 5, opcode width, taken from idata[DATA_W-1 -: OP_W]
NUM_ENG, 4, engine count (1..8)
NUM_CFG, 16, configuration registers (fixed 4-bit index)
LOOP_DEPTH, 2, hardware loop stack depth (1..4)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins execution at iaddr 0 from IDLE
iaddr  out  IADDR_W  instruction address (registered)
idata  in  DATA_W  instruction at iaddr, combinational, same cycle
eng_start  out  NUM_ENG  one-hot one-cycle start pulse
eng_arg  out  DATA_W-OP_W-3  argument, valid with eng_start
eng_done  in  NUM_ENG  per-engine one-cycle completion pulse
cfg_flat  out  NUM_CFG*(DATA_W-OP_W-4)  config registers; reg k at slice k
busy  out  1  high outside IDLE/HALT/ERR
done  out  1  sticky; EOC retired
err  out  1  sticky; illegal op, loop over/underflow, or bad engine id

Behaviour:
- Reset, synchronous with rst=1 at posedge: state=IDLE, iaddr=0, all cfg regs 0, eng_busy=0, loop stack empty, eng_start=0, eng_arg=0, busy=0, done=0, err=0. Reset mid-run aborts; eng_done pulses from before reset are ignored.
- States: IDLE, DEC, STALL, SYNC, DRAIN, HALT, ERR.
- IDLE: on start go to DEC with iaddr=0. start is ignored in any other state.
- DEC: decodes idata each cycle. A non-stalling instruction retires in 1 cycle with iaddr+1, unless it is a taken ENDL.
- Opcodes:
  - 0 NOP.
  - 1 CFG: cfg[idata[26:23]] <= idata[22:0]. Visible on cfg_flat the next cycle.
  - 2 RUN: engine e=idata[26:24], arg=idata[23:0].
    - e>=NUM_ENG: go to ERR.
    - eng_busy[e]=0, or eng_done[e]=1 this cycle (bypass): eng_start[e]=1 and eng_arg=arg next cycle, eng_busy[e] set, iaddr+1.
    - Otherwise: go to STALL, iaddr held.
  - 3 LOOP: push {start=iaddr+1, count=idata[15:0]}. count 0 is treated as 1. Push when the stack is full goes to ERR.
  - 4 ENDL: empty stack goes to ERR. If top.count>1, decrement and set iaddr=top.start. Otherwise pop and iaddr+1.
  - 5 SYNC: go to SYNC.
  - 31 EOC: go to DRAIN.
  - Any other opcode: ERR.
- eng_busy update per bit: busy_next = (busy & ~eng_done) | start_issued. A same-cycle done and new start on one engine leaves busy=1.
- STALL: re-evaluate the held RUN each cycle. Issue on the first cycle eng_done[e] is seen, then return to DEC.
- SYNC: when eng_busy==0 (including dones arriving that cycle), iaddr+1 and return to DEC.
- DRAIN: when eng_busy==0, go to HALT with done=1.
- HALT, ERR: iaddr frozen, no starts; exit only via rst. ERR sets err=1 and leaves cfg unchanged.
- iaddr wraps modulo 2^IADDR_W with no error.
- At most one eng_start bit is high per cycle.
- eng_arg holds its last value when no start is issued.

Test Plan:
- Config write: CFG idx 3 val 0x12345, then EOC. Required: cfg slice 3 = 0x12345, all other slices 0, done=1 at cycle 4 after start, err=0.
- Overlap and stall: RUN e0 a=5; RUN e1 a=6; RUN e0 a=7; bench holds e0 done off for 10 cycles. Required: starts at cycles 1 and 2; third start exactly 1 cycle after e0 done pulse; iaddr held at 2 during the stall.
- Nested loop: LOOP 3; LOOP 2; RUN e0; ENDL; ENDL; SYNC; EOC, with instant done. Required: exactly 6 e0 starts, then done=1.
- Loop errors: 3 LOOPs with LOOP_DEPTH=2 gives err=1 at the third. A lone ENDL gives err=1. Opcode 7 gives err=1. In all cases no further starts.
- Simultaneous done/start: issue RUN e2 in the same cycle e2's eng_done arrives. Required: no stall, eng_busy[2] remains 1, SYNC then waits for the next done.
- Mid-run reset: assert rst during STALL. Required: next cycle iaddr=0, eng_start=0, busy=0, state IDLE; a late eng_done is ignored; a fresh start re-executes from 0.
